adder_arb_16b: RTL and testbench

ADDER_ARB_16B -- requirements
Module: adder_arb_16b

---
 rtl/adder_arb_16b_if.sv | 27 ++
 rtl/adder_arb_16b.sv | 60 ++++++
 tb/tb_adder_arb_16b.sv | 116 +++++++++++
 3 files changed

// File: rtl/adder_arb_16b_if.sv
// adder_arb_16b_if: requester, result and counter signals shared by the arbitrated adder and its driver
interface adder_arb_16b_if #(
  parameter int WIDTH = 16
);
  logic             req0_valid;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req0_ready;
  logic             req1_valid;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             req1_ready;
  logic             res_valid;
  logic [WIDTH-1:0] res_sum;
  logic             res_carry;
  logic             res_id;
  logic             res_ready;
  logic [15:0]      op_count;
  modport master (
    output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, res_ready,
    input  req0_ready, req1_ready, res_valid, res_sum, res_carry, res_id, op_count
  );
  modport slave (
    input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, res_ready,
    output req0_ready, req1_ready, res_valid, res_sum, res_carry, res_id, op_count
  );
endinterface

// File: rtl/adder_arb_16b.sv
// adder_arb_16b: one shared adder, round-robin arbitrated between two requesters, single result register
module adder_arb_16b #(
  parameter int WIDTH = 16
) (
  input logic             clk,
  input logic             rst_n,
  adder_arb_16b_if.slave  bus
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t           state_q, state_d;
  logic             prio_q, prio_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             id_q, id_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             can_accept, gnt0, gnt1, accept;
  logic [WIDTH-1:0] op_a, op_b;
  logic [WIDTH:0]   add;
  // grant, shared adder and next-state; readys are masked while reset is held
  always_comb begin
    can_accept = (state_q == EMPTY) || bus.res_ready;
    gnt0       = rst_n && can_accept && bus.req0_valid && (!bus.req1_valid || !prio_q);
    gnt1       = rst_n && can_accept && bus.req1_valid && !gnt0;
    accept     = gnt0 || gnt1;
    op_a       = gnt1 ? bus.req1_a : bus.req0_a;
    op_b       = gnt1 ? bus.req1_b : bus.req0_b;
    add        = {1'b0, op_a} + {1'b0, op_b};
    state_d    = accept ? FULL : (bus.res_ready ? EMPTY : state_q);
    prio_d     = accept ? gnt0 : prio_q;
    sum_d      = accept ? add[WIDTH-1:0] : sum_q;
    carry_d    = accept ? add[WIDTH] : carry_q;
    id_d       = accept ? gnt1 : id_q;
    cnt_d      = (state_q == FULL && bus.res_ready) ? cnt_q + 16'd1 : cnt_q;
  end
  // result register, arbitration pointer and delivery counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      prio_q  <= 1'b0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      id_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
    end
  end
  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;
  assign bus.res_valid  = (state_q == FULL);
  assign bus.res_sum    = sum_q;
  assign bus.res_carry  = carry_q;
  assign bus.res_id     = id_q;
  assign bus.op_count   = cnt_q;
endmodule

// File: tb/tb_adder_arb_16b.sv
// tb_adder_arb_16b: directed steps with a result scoreboard and a small arbitration model
module tb_adder_arb_16b;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cmp = 0;
  int   errs = 0;
  logic        m_full = 1'b0;
  logic        m_prio = 1'b0;
  logic [15:0] m_cnt = 16'd0;
  logic [17:0] sb[$];
  adder_arb_16b_if #(.WIDTH(16)) bus ();
  adder_arb_16b #(.WIDTH(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input logic v0, input logic [15:0] a0, input logic [15:0] b0,
                     input logic v1, input logic [15:0] a1, input logic [15:0] b1, input logic rr);
    logic can, g0, g1;
    logic [16:0] s;
    bus.req0_valid = v0; bus.req0_a = a0; bus.req0_b = b0;
    bus.req1_valid = v1; bus.req1_a = a1; bus.req1_b = b1;
    bus.res_ready  = rr;
    @(negedge clk);
    can = !m_full || rr;
    g0  = can && v0 && (!v1 || !m_prio);
    g1  = can && v1 && !g0;
    chk("req0_ready", 32'(bus.req0_ready), 32'(g0));
    chk("req1_ready", 32'(bus.req1_ready), 32'(g1));
    chk("res_valid", 32'(bus.res_valid), 32'(m_full));
    chk("op_count", 32'(bus.op_count), 32'(m_cnt));
    if (m_full) begin
      if (sb.size() == 0) begin
        cmp++; errs++;
        $error("FAIL scoreboard: observed result expected none");
      end else begin
        chk("result", 32'({bus.res_id, bus.res_carry, bus.res_sum}), 32'(sb[0]));
        if (rr) void'(sb.pop_front());
      end
    end
    if (g0 || g1) begin
      s = g1 ? 17'(a1) + 17'(b1) : 17'(a0) + 17'(b0);
      sb.push_back({g1, s});
    end
    @(posedge clk); #1;
    if (m_full && rr) m_cnt = m_cnt + 16'd1;
    if (g0 || g1) begin
      m_full = 1'b1;
      m_prio = g0;
    end else if (rr) m_full = 1'b0;
  endtask
  task automatic idle(input logic rr);
    cyc(1'b0, 16'($urandom), 16'($urandom), 1'b0, 16'($urandom), 16'($urandom), rr);
  endtask
  task automatic both(input logic rr);
    cyc(1'b1, 16'($urandom), 16'($urandom), 1'b1, 16'($urandom), 16'($urandom), rr);
  endtask
  initial begin
    int d;
    bus.req0_valid = 1'b1; bus.req0_a = 16'h1111; bus.req0_b = 16'h2222;
    bus.req1_valid = 1'b1; bus.req1_a = 16'h3333; bus.req1_b = 16'h4444;
    bus.res_ready  = 1'b1;
    #3;
    chk("rst_req0_ready", 32'(bus.req0_ready), 32'd0);
    chk("rst_req1_ready", 32'(bus.req1_ready), 32'd0);
    chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_res", 32'({bus.res_id, bus.res_carry, bus.res_sum}), 32'd0);
    chk("rst_op_count", 32'(bus.op_count), 32'd0);
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    cyc(1'b1, 16'h1234, 16'h0001, 1'b0, 16'hAAAA, 16'h5555, 1'b1);
    chk("single_sum", 32'(bus.res_sum), 32'h1235);
    chk("single_carry_id", 32'({bus.res_id, bus.res_carry}), 32'd0);
    chk("single_valid", 32'(bus.res_valid), 32'd1);
    idle(1'b1);
    chk("single_count", 32'(bus.op_count), 32'd1);
    cyc(1'b0, 16'h0F0F, 16'hF0F0, 1'b1, 16'hFFFF, 16'h0001, 1'b1);
    chk("ovf1_sum", 32'(bus.res_sum), 32'h0000);
    chk("ovf1_carry_id", 32'({bus.res_id, bus.res_carry}), 32'h3);
    cyc(1'b0, 16'h0000, 16'h0000, 1'b1, 16'h8000, 16'h8000, 1'b1);
    chk("ovf2_sum_carry", 32'({bus.res_carry, bus.res_sum}), 32'h10000);
    idle(1'b1);
    for (int i = 0; i < 8; i++) both(1'b1);
    for (int i = 0; i < 6; i++) both(1'b0);
    for (int i = 0; i < 3; i++) both(1'b1);
    idle(1'b1);
    idle(1'b1);
    both(1'b0);
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.res_valid), 32'd0);
    chk("mid_rst_count", 32'(bus.op_count), 32'd0);
    chk("mid_rst_res", 32'({bus.res_id, bus.res_carry, bus.res_sum}), 32'd0);
    chk("mid_rst_readys", 32'({bus.req1_ready, bus.req0_ready}), 32'd0);
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    #1 rst_n = 1'b1;
    m_full = 1'b0; m_prio = 1'b0; m_cnt = 16'd0; sb.delete();
    @(posedge clk); #1;
    cyc(1'b1, 16'h0001, 16'h0002, 1'b1, 16'h0003, 16'h0004, 1'b1);
    chk("post_rst_id", 32'(bus.res_id), 32'd0);
    d = 0;
    while (d < 65536) begin
      if (m_full) d++;
      both(1'b1);
    end
    chk("wrap_count", 32'(bus.op_count), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end
endmodule
